// File: rtl/fft_power_averager.sv
// fft_power_averager
//   Streaming post-processor placed between the FFT core and the output data
//   controller. Each complex bin {imag, real} is converted to power
//   (re^2 + im^2), accumulated per bin over 2^AVG_LOG2 consecutive frames in an
//   on-chip RAM, and the floor-averaged spectrum is emitted once per averaging
//   period together with its bin index and a last-bin flag.
//
// Ports
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_data_valid    input beat valid
//   i_data          {imag, real}, both signed DATA_W
//   i_data_last     marks the final bin of an input frame
//   o_data_ready    block can accept an input beat this cycle
//   o_data_valid    averaged output beat valid
//   o_data          averaged power, unsigned, 2*DATA_W+1 bits
//   o_data_index    bin index of o_data
//   o_data_last     set with bin N-1
//   i_data_ready    downstream accepts the output beat
//   i_clear         synchronous restart of the averaging period
//   o_frame_err     one-cycle pulse when i_data_last disagrees with the bin count
module fft_power_averager #(
  parameter int DATA_W   = 24,
  parameter int LOG2_N   = 10,
  parameter int AVG_LOG2 = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_data_valid,
  input  logic [2*DATA_W-1:0]   i_data,
  input  logic                  i_data_last,
  output logic                  o_data_ready,
  output logic                  o_data_valid,
  output logic [2*DATA_W:0]     o_data,
  output logic [LOG2_N-1:0]     o_data_index,
  output logic                  o_data_last,
  input  logic                  i_data_ready,
  input  logic                  i_clear,
  output logic                  o_frame_err
);

  localparam int PWR_W = 2*DATA_W + 1;
  localparam int ACC_W = PWR_W + AVG_LOG2;
  localparam int F_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int N     = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] K_LAST = LOG2_N'(N - 1);
  localparam logic [F_W-1:0]    F_LAST = F_W'((1 << AVG_LOG2) - 1);

  logic                     en;
  logic                     accept;
  logic [LOG2_N-1:0]        k;
  logic [F_W-1:0]           f;
  logic                     k_at_end;
  logic                     early_last;
  logic                     missing_last;
  logic signed [2*DATA_W-1:0] re_x;
  logic signed [2*DATA_W-1:0] im_x;

  // S1 registers
  logic                     v1;
  logic signed [2*DATA_W-1:0] sq_re;
  logic signed [2*DATA_W-1:0] sq_im;
  logic [LOG2_N-1:0]        k1;
  logic                     first1;
  logic                     last1;

  // S2 registers
  logic                     v2;
  logic [PWR_W-1:0]         p2;
  logic [LOG2_N-1:0]        k2;
  logic                     first2;
  logic                     last2;
  logic [ACC_W-1:0]         acc_rd;

  // S3 combinational
  logic [ACC_W-1:0]         p_ext;
  logic [ACC_W-1:0]         acc_sum;

  logic [ACC_W-1:0]         acc_ram [N];

  // Every stage, including the output register, moves together; a stalled
  // output freezes the whole pipeline, so the ready path back to the source is
  // combinational from i_data_ready.
  assign en           = !o_data_valid || i_data_ready;
  assign o_data_ready = en && !i_clear;
  assign accept       = i_data_valid && o_data_ready;

  assign k_at_end     = (k == K_LAST);
  assign early_last   = i_data_last && !k_at_end;
  assign missing_last = k_at_end && !i_data_last;

  // Sign-extend to the product width so the multiply is done at full width.
  assign re_x = {{DATA_W{i_data[DATA_W-1]}}, i_data[DATA_W-1:0]};
  assign im_x = {{DATA_W{i_data[2*DATA_W-1]}}, i_data[2*DATA_W-1:DATA_W]};

  // Bin and frame counters. An early last restarts the averaging period so a
  // short frame never gets mixed into a partial average; a missing last is
  // only flagged and the count wraps as usual.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k           <= '0;
      f           <= '0;
      o_frame_err <= 1'b0;
    end else if (i_clear) begin
      k           <= '0;
      f           <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= accept && (early_last || missing_last);
      if (accept) begin
        if (early_last) begin
          k <= '0;
          f <= '0;
        end else if (k_at_end) begin
          k <= '0;
          f <= (f == F_LAST) ? '0 : f + 1'b1;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  // S1: squares of both components plus the beat's bin/frame position.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1     <= 1'b0;
      sq_re  <= '0;
      sq_im  <= '0;
      k1     <= '0;
      first1 <= 1'b0;
      last1  <= 1'b0;
    end else if (i_clear) begin
      v1 <= 1'b0;
    end else if (en) begin
      v1     <= accept;
      sq_re  <= re_x * re_x;
      sq_im  <= im_x * im_x;
      k1     <= k;
      first1 <= (f == '0);
      last1  <= (f == F_LAST);
    end
  end

  // S2: power sum. Both squares are non-negative, so one extra bit holds the
  // sum without overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2     <= 1'b0;
      p2     <= '0;
      k2     <= '0;
      first2 <= 1'b0;
      last2  <= 1'b0;
    end else if (i_clear) begin
      v2 <= 1'b0;
    end else if (en) begin
      v2     <= v1;
      p2     <= {1'b0, sq_re} + {1'b0, sq_im};
      k2     <= k1;
      first2 <= first1;
      last2  <= last1;
    end
  end

  assign p_ext   = ACC_W'(p2);
  assign acc_sum = first2 ? p_ext : (acc_rd + p_ext);

  // Accumulator RAM with registered read. The read of a bin in S2 and its
  // write in S3 are always for different bins because a bin recurs only after
  // N >= 4 beats, so no forwarding path is needed.
  always_ff @(posedge i_clk) begin
    if (en) begin
      acc_rd <= acc_ram[k1];
    end
    if (en && v2 && !i_clear) begin
      acc_ram[k2] <= acc_sum;
    end
  end

  // S3 output register: only the final frame of a period produces a beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data_valid <= 1'b0;
      o_data       <= '0;
      o_data_index <= '0;
      o_data_last  <= 1'b0;
    end else if (i_clear) begin
      o_data_valid <= 1'b0;
    end else if (en) begin
      o_data_valid <= v2 && last2;
      if (v2 && last2) begin
        o_data       <= acc_sum[ACC_W-1:AVG_LOG2];
        o_data_index <= k2;
        o_data_last  <= (k2 == K_LAST);
      end
    end
  end

endmodule

// File: tb/tb_fft_power_averager.sv
// tb_fft_power_averager
//   Directed bench for fft_power_averager. One instance uses an 8-bin frame
//   averaged over 4 frames; a second uses a 4-bin frame in pass-through power
//   mode. Output beats are collected by a monitor and compared against
//   hand-computed spectra in each scenario task.
module tb_fft_power_averager;

  typedef struct {
    logic [48:0] data;
    logic [2:0]  index;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_last, down_ready, clear;
  logic [47:0] in_data;
  logic        out_ready, out_valid, out_last, frame_err;
  logic [48:0] out_data;
  logic [2:0]  out_index;

  logic        p_in_valid, p_in_last, p_down_ready, p_clear;
  logic [47:0] p_in_data;
  logic        p_out_ready, p_out_valid, p_out_last, p_frame_err;
  logic [48:0] p_out_data;
  logic [1:0]  p_out_index;

  beat_t q_main[$];
  beat_t q_p[$];
  int    err_main = 0;
  int    err_p    = 0;
  int    passed   = 0;
  int    total    = 0;
  int    fre[8];
  int    fim[8];

  fft_power_averager #(.DATA_W(24), .LOG2_N(3), .AVG_LOG2(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data_valid(in_valid), .i_data(in_data), .i_data_last(in_last),
    .o_data_ready(out_ready), .o_data_valid(out_valid), .o_data(out_data),
    .o_data_index(out_index), .o_data_last(out_last),
    .i_data_ready(down_ready), .i_clear(clear), .o_frame_err(frame_err)
  );

  fft_power_averager #(.DATA_W(24), .LOG2_N(2), .AVG_LOG2(0)) dut_p (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data_valid(p_in_valid), .i_data(p_in_data), .i_data_last(p_in_last),
    .o_data_ready(p_out_ready), .o_data_valid(p_out_valid), .o_data(p_out_data),
    .o_data_index(p_out_index), .o_data_last(p_out_last),
    .i_data_ready(p_down_ready), .i_clear(p_clear), .o_frame_err(p_frame_err)
  );

  always #5 clk = ~clk;

  // Collect every completed output handshake and every error pulse.
  always @(negedge clk) begin
    if (rst_n && out_valid && down_ready)
      q_main.push_back('{data: out_data, index: out_index, last: out_last});
    if (rst_n && p_out_valid && p_down_ready)
      q_p.push_back('{data: p_out_data, index: {1'b0, p_out_index}, last: p_out_last});
    if (rst_n && frame_err) err_main++;
    if (rst_n && p_frame_err) err_p++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; err is o_frame_err right
  // after the accepting edge.
  task automatic send_beat(input int re, input int im, input bit last, output bit err);
    bit done;
    done = 1'b0;
    err  = 1'b0;
    in_valid = 1'b1;
    in_data  = {im[23:0], re[23:0]};
    in_last  = last;
    for (int n = 0; n < 60 && !done; n++) begin
      #1;
      if (out_ready) begin
        tick();
        err  = frame_err;
        done = 1'b1;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++;
    if (!done) $display("[TB] FAIL send_timeout: accepted=%0b want 1", done);
    else passed++;
  endtask

  task automatic send_frame(input bit drop_last, output int errs);
    bit e;
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      send_beat(fre[k], fim[k], (k == 7) && !drop_last, e);
      errs += int'(e);
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b want 0", out_valid); else passed++;
    total++; if (out_data !== 49'd0) $display("[TB] FAIL reset_data: got %0d want 0", out_data); else passed++;
    total++; if (out_index !== 3'd0) $display("[TB] FAIL reset_index: got %0d want 0", out_index); else passed++;
    total++; if (out_last !== 1'b0) $display("[TB] FAIL reset_last: got %0b want 0", out_last); else passed++;
    total++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_err: got %0b want 0", frame_err); else passed++;
    total++; if (p_out_valid !== 1'b0) $display("[TB] FAIL reset_p_valid: got %0b want 0", p_out_valid); else passed++;
    rst_n = 1'b1;
    tick();
    total++; if (out_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %0b want 1", out_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid_after: got %0b want 0", out_valid); else passed++;
  endtask

  task automatic test_passthrough();
    int re, im;
    re = 3;
    im = -4;
    p_in_valid = 1'b1;
    p_in_data  = {im[23:0], re[23:0]};
    p_in_last  = 1'b0;
    #1;
    total++; if (p_out_ready !== 1'b1) $display("[TB] FAIL pass_ready: got %0b want 1", p_out_ready); else passed++;
    tick();
    p_in_valid = 1'b0;
    total++; if (p_out_valid !== 1'b0) $display("[TB] FAIL pass_lat1: got %0b want 0", p_out_valid); else passed++;
    tick();
    total++; if (p_out_valid !== 1'b0) $display("[TB] FAIL pass_lat2: got %0b want 0", p_out_valid); else passed++;
    tick();
    total++; if (p_out_valid !== 1'b1) $display("[TB] FAIL pass_lat3: got %0b want 1", p_out_valid); else passed++;
    total++; if (p_out_data !== 49'd25) $display("[TB] FAIL pass_data: got %0d want 25", p_out_data); else passed++;
    total++; if (p_out_index !== 2'd0) $display("[TB] FAIL pass_index: got %0d want 0", p_out_index); else passed++;
    total++; if (p_out_last !== 1'b0) $display("[TB] FAIL pass_last: got %0b want 0", p_out_last); else passed++;
    for (int k = 1; k < 4; k++) begin
      re = k;
      im = 2 * k;
      p_in_valid = 1'b1;
      p_in_data  = {im[23:0], re[23:0]};
      p_in_last  = (k == 3);
      tick();
    end
    p_in_valid = 1'b0;
    p_in_last  = 1'b0;
    repeat (5) tick();
    total++; if (q_p.size() !== 4) $display("[TB] FAIL pass_count: got %0d want 4", q_p.size()); else passed++;
    for (int k = 1; k < 4; k++) begin
      beat_t b;
      if (k < q_p.size()) b = q_p[k];
      else begin b.data = 'x; b.index = 'x; b.last = 1'bx; end
      total++;
      if (b.data !== 49'(5*k*k) || b.index !== 3'(k) || b.last !== (k == 3))
        $display("[TB] FAIL pass_beat%0d: got data=%0d idx=%0d last=%0b want data=%0d idx=%0d last=%0b",
                 k, b.data, b.index, b.last, 5*k*k, k, (k == 3));
      else passed++;
    end
    total++; if (err_p !== 0) $display("[TB] FAIL pass_err: got %0d want 0", err_p); else passed++;
  endtask

  task automatic test_average();
    int e;
    q_main.delete();
    for (int k = 0; k < 8; k++) begin fre[k] = k; fim[k] = 0; end
    repeat (3) send_frame(1'b0, e);
    repeat (4) tick();
    total++; if (q_main.size() !== 0) $display("[TB] FAIL avg_early: got %0d want 0", q_main.size()); else passed++;
    send_frame(1'b0, e);
    repeat (6) tick();
    total++; if (q_main.size() !== 8) $display("[TB] FAIL avg_count: got %0d want 8", q_main.size()); else passed++;
    for (int k = 0; k < 8; k++) begin
      beat_t b;
      if (k < q_main.size()) b = q_main[k];
      else begin b.data = 'x; b.index = 'x; b.last = 1'bx; end
      total++;
      if (b.data !== 49'(k*k) || b.index !== 3'(k) || b.last !== (k == 7))
        $display("[TB] FAIL avg_beat%0d: got data=%0d idx=%0d last=%0b want data=%0d idx=%0d last=%0b",
                 k, b.data, b.index, b.last, k*k, k, (k == 7));
      else passed++;
    end
    total++; if (err_main !== 0) $display("[TB] FAIL avg_err: got %0d want 0", err_main); else passed++;
  endtask

  task automatic test_floor();
    int e;
    int r0[4]  = '{1, 1, 1, 3};
    int want[8] = '{3, 0, 4, 6, 0, 0, 0, 0};
    q_main.delete();
    for (int fr = 0; fr < 4; fr++) begin
      for (int k = 0; k < 8; k++) begin fre[k] = 0; fim[k] = 0; end
      fre[0] = r0[fr];
      fre[1] = (fr == 0) ? 1 : 0;
      fim[2] = -2;
      fre[3] = (fr == 0) ? 5 : 0;
      send_frame(1'b0, e);
    end
    repeat (6) tick();
    total++; if (q_main.size() !== 8) $display("[TB] FAIL floor_count: got %0d want 8", q_main.size()); else passed++;
    for (int k = 0; k < 8; k++) begin
      beat_t b;
      if (k < q_main.size()) b = q_main[k];
      else begin b.data = 'x; b.index = 'x; b.last = 1'bx; end
      total++;
      if (b.data !== 49'(want[k]) || b.index !== 3'(k))
        $display("[TB] FAIL floor_beat%0d: got data=%0d idx=%0d want data=%0d idx=%0d",
                 k, b.data, b.index, want[k], k);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int e;
    q_main.delete();
    for (int k = 0; k < 8; k++) begin fre[k] = k + 1; fim[k] = k; end
    fork
      begin
        repeat (4) send_frame(1'b0, e);
      end
      begin
        logic [48:0] hold_data;
        logic [2:0]  hold_idx;
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
          if (out_valid) seen = 1'b1;
          else tick();
        end
        total++; if (!seen) $display("[TB] FAIL bp_wait: valid=%0b want 1", out_valid); else passed++;
        down_ready = 1'b0;
        hold_data  = out_data;
        hold_idx   = out_index;
        for (int c = 0; c < 5; c++) begin
          tick();
          total++;
          if (out_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== hold_data || out_index !== hold_idx)
            $display("[TB] FAIL bp_hold%0d: got ready=%0b valid=%0b data=%0d idx=%0d want ready=0 valid=1 data=%0d idx=%0d",
                     c, out_ready, out_valid, out_data, out_index, hold_data, hold_idx);
          else passed++;
        end
        down_ready = 1'b1;
      end
    join
    for (int n = 0; n < 30 && q_main.size() < 8; n++) tick();
    total++; if (q_main.size() !== 8) $display("[TB] FAIL bp_count: got %0d want 8", q_main.size()); else passed++;
    for (int k = 0; k < 8; k++) begin
      beat_t b;
      int    w;
      w = (k + 1) * (k + 1) + k * k;
      if (k < q_main.size()) b = q_main[k];
      else begin b.data = 'x; b.index = 'x; b.last = 1'bx; end
      total++;
      if (b.data !== 49'(w) || b.index !== 3'(k) || b.last !== (k == 7))
        $display("[TB] FAIL bp_beat%0d: got data=%0d idx=%0d last=%0b want data=%0d idx=%0d last=%0b",
                 k, b.data, b.index, b.last, w, k, (k == 7));
      else passed++;
    end
  endtask

  task automatic test_frame_err();
    int e;
    int base;
    bit be;
    int early;
    q_main.delete();
    base = err_main;
    for (int k = 0; k < 8; k++) begin fre[k] = 7; fim[k] = 0; end
    send_frame(1'b0, e);
    early = 0;
    for (int k = 0; k < 3; k++) begin
      send_beat(9, 9, 1'b0, be);
      early += int'(be);
    end
    total++; if (early !== 0) $display("[TB] FAIL ferr_none: got %0d want 0", early); else passed++;
    send_beat(9, 9, 1'b1, be);
    total++; if (be !== 1'b1) $display("[TB] FAIL ferr_pulse: got %0b want 1", be); else passed++;
    tick();
    total++; if (frame_err !== 1'b0) $display("[TB] FAIL ferr_width: got %0b want 0", frame_err); else passed++;
    for (int k = 0; k < 8; k++) begin fre[k] = k + 2; fim[k] = 0; end
    send_frame(1'b1, e);
    total++; if (e !== 1) $display("[TB] FAIL ferr_missing: got %0d want 1", e); else passed++;
    repeat (2) send_frame(1'b0, e);
    repeat (4) tick();
    total++; if (q_main.size() !== 0) $display("[TB] FAIL ferr_early: got %0d want 0", q_main.size()); else passed++;
    send_frame(1'b0, e);
    repeat (6) tick();
    total++; if (q_main.size() !== 8) $display("[TB] FAIL ferr_count: got %0d want 8", q_main.size()); else passed++;
    for (int k = 0; k < 8; k++) begin
      beat_t b;
      if (k < q_main.size()) b = q_main[k];
      else begin b.data = 'x; b.index = 'x; b.last = 1'bx; end
      total++;
      if (b.data !== 49'((k+2)*(k+2)) || b.index !== 3'(k))
        $display("[TB] FAIL ferr_beat%0d: got data=%0d idx=%0d want data=%0d idx=%0d",
                 k, b.data, b.index, (k+2)*(k+2), k);
      else passed++;
    end
    total++; if (err_main - base !== 2) $display("[TB] FAIL ferr_total: got %0d want 2", err_main - base); else passed++;
  endtask

  task automatic test_clear();
    int e;
    bit be;
    int base;
    for (int k = 0; k < 8; k++) begin fre[k] = k + 1; fim[k] = 0; end
    repeat (3) send_frame(1'b0, e);
    for (int k = 0; k < 5; k++) send_beat(fre[k], 0, 1'b0, be);
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL clr_pre: got %0b want 1", out_valid); else passed++;
    base = err_main;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 48'd5;
    clear    = 1'b1;
    #1;
    total++; if (out_ready !== 1'b0) $display("[TB] FAIL clr_ready: got %0b want 0", out_ready); else passed++;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL clr_valid: got %0b want 0", out_valid); else passed++;
    total++; if (frame_err !== 1'b0) $display("[TB] FAIL clr_err: got %0b want 0", frame_err); else passed++;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (out_valid !== 1'b0) $display("[TB] FAIL clr_flush%0d: got %0b want 0", c, out_valid); else passed++;
    end
    total++; if (err_main !== base) $display("[TB] FAIL clr_err_count: got %0d want %0d", err_main, base); else passed++;
    q_main.delete();
    for (int k = 0; k < 8; k++) begin fre[k] = k; fim[k] = 1; end
    repeat (3) send_frame(1'b0, e);
    repeat (4) tick();
    total++; if (q_main.size() !== 0) $display("[TB] FAIL clr_early: got %0d want 0", q_main.size()); else passed++;
    send_frame(1'b0, e);
    repeat (6) tick();
    total++; if (q_main.size() !== 8) $display("[TB] FAIL clr_count: got %0d want 8", q_main.size()); else passed++;
    for (int k = 0; k < 8; k++) begin
      beat_t b;
      if (k < q_main.size()) b = q_main[k];
      else begin b.data = 'x; b.index = 'x; b.last = 1'bx; end
      total++;
      if (b.data !== 49'(k*k + 1) || b.index !== 3'(k) || b.last !== (k == 7))
        $display("[TB] FAIL clr_beat%0d: got data=%0d idx=%0d last=%0b want data=%0d idx=%0d last=%0b",
                 k, b.data, b.index, b.last, k*k + 1, k, (k == 7));
      else passed++;
    end
  endtask

  task automatic test_max_reset();
    int e;
    bit be;
    logic [48:0] want_max;
    want_max = 49'h8000_0000_0000;
    for (int k = 0; k < 8; k++) begin fre[k] = -8388608; fim[k] = -8388608; end
    repeat (3) send_frame(1'b0, e);
    down_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_beat(fre[k], fim[k], 1'b0, be);
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL max_valid: got %0b want 1", out_valid); else passed++;
    total++; if (out_data !== want_max) $display("[TB] FAIL max_data: got %0h want %0h", out_data, want_max); else passed++;
    total++; if (out_index !== 3'd0) $display("[TB] FAIL max_index: got %0d want 0", out_index); else passed++;
    total++; if (out_ready !== 1'b0) $display("[TB] FAIL max_ready: got %0b want 0", out_ready); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL arst_valid: got %0b want 0", out_valid); else passed++;
    total++; if (out_data !== 49'd0) $display("[TB] FAIL arst_data: got %0h want 0", out_data); else passed++;
    total++; if (out_index !== 3'd0) $display("[TB] FAIL arst_index: got %0d want 0", out_index); else passed++;
    total++; if (out_last !== 1'b0) $display("[TB] FAIL arst_last: got %0b want 0", out_last); else passed++;
    total++; if (out_ready !== 1'b1) $display("[TB] FAIL arst_ready: got %0b want 1", out_ready); else passed++;
    total++; if (p_out_data !== 49'd0) $display("[TB] FAIL arst_p_data: got %0d want 0", p_out_data); else passed++;
    down_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_last      = 1'b0;
    down_ready   = 1'b1;
    clear        = 1'b0;
    p_in_valid   = 1'b0;
    p_in_data    = '0;
    p_in_last    = 1'b0;
    p_down_ready = 1'b1;
    p_clear      = 1'b0;
    test_reset();
    test_passthrough();
    test_average();
    test_floor();
    test_back_to_back();
    test_frame_err();
    test_clear();
    test_max_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fft_power_averager.md
Name: fft_power_averager

Overview:
- Streaming post-processor for the FFT chain. It sits between the FFT core output and the output data controller.
- Converts each complex bin to power (re^2 + im^2).
- Averages power per bin over 2^AVG_LOG2 consecutive frames in an on-chip accumulator RAM.
- Emits one averaged spectrum per averaging period, with bin index and last flag, over valid/ready handshakes on both sides.

Parameters:
- DATA_W, 24: width of each signed component; input word = {imag, real}, 2*DATA_W bits.
- LOG2_N, 10: frame length N = 2^LOG2_N bins; legal range is LOG2_N >= 2.
- AVG_LOG2, 2: number of frames averaged = 2^AVG_LOG2; 0 means pass-through power, every frame output.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data_valid  in  1  input beat valid.
- i_data  in  2*DATA_W  [2*DATA_W-1:DATA_W] = imag signed, [DATA_W-1:0] = real signed.
- i_data_last  in  1  marks the final bin of a frame.
- o_data_ready  out  1  block accepts an input beat.
- o_data_valid  out  1  output beat valid.
- o_data  out  2*DATA_W+1  averaged power, unsigned.
- o_data_index  out  LOG2_N  bin index of o_data.
- o_data_last  out  1  asserted with bin N-1.
- i_data_ready  in  1  downstream accepts output.
- i_clear  in  1  synchronous restart of averaging.
- o_frame_err  out  1  one-cycle pulse on frame misalignment.

Behaviour:
- Clock is i_clk. Reset is asynchronous, active-low, on i_rst_n. On reset:
  - o_data_valid=0, o_data=0, o_data_index=0, o_data_last=0, o_frame_err=0.
  - All pipeline valid bits 0; bin counter k=0; frame counter f=0.
  - Accumulator RAM is not reset; frame 0 overwrites it.
- Pipeline enable: en = !o_data_valid || i_data_ready.
  - o_data_ready = en. This is a combinational path from i_data_ready; it is intentional.
  - Input is accepted when i_data_valid && en.
  - All stages advance only when en=1. When en=0, every stage holds and outputs stay stable.
- Stage S1: register re*re and im*im as signed 2*DATA_W products. Register k, f, last-frame flag.
  - k increments per accepted beat and wraps N-1 -> 0.
  - On wrap, f increments, wrapping 2^AVG_LOG2-1 -> 0.
- Stage S2: p = re^2 + im^2, zero-extended to 2*DATA_W+1 bits; never overflows. Issue RAM read of acc[k].
- Stage S3:
  - If f == 0: write acc[k] = p.
  - Otherwise: write acc[k] = acc[k] + p. RAM width is 2*DATA_W+1+AVG_LOG2; no saturation needed.
  - If f == 2^AVG_LOG2-1: load output register with o_data = (acc[k]+p) >> AVG_LOG2 (floor), o_data_index = k, o_data_last = (k==N-1), o_data_valid=1.
  - Frames with f != last produce no output beats.
- Latency: 3 cycles from accept to o_data_valid, with no stall.
- Read/write hazard: the same bin is revisited N >= 4 beats later, so no forwarding is required.
- Frame alignment:
  - i_data_last at k != N-1: pulse o_frame_err. The next accepted beat gets k=0, f=0, so the partial average is discarded. Beats already in the pipeline still complete.
  - k == N-1 without i_data_last: pulse o_frame_err; wrap normally.
- i_clear:
  - Next cycle: k=0, f=0, all pipeline valids and o_data_valid cleared. An output beat pending handshake is dropped.
  - An input beat presented with i_clear is not accepted; o_data_ready=0 while i_clear=1.
- Simultaneous i_clear and i_data_last: i_clear wins; no o_frame_err.
- Reset asserted mid-frame forces all outputs to their reset values immediately.

Test Plan:
- AVG_LOG2=0, LOG2_N=2; beat re=3, im=-4 -> o_data=25, index 0, three cycles after accept, i_data_ready=1.
- LOG2_N=3, AVG_LOG2=2; four frames with bin k: re=k, im=0 -> no output during frames 0-2; frame 3 outputs k^2 for k=0..7, o_data_last only at k=7.
- Same config; bin 0 re = 1,1,1,3 over four frames -> o_data=(1+1+1+9)>>2=3; bin 1 re = 1,0,0,0 -> o_data=0 (floor).
- Backpressure: during output frame hold i_data_ready=0 for 5 cycles -> o_data_ready=0, o_data/index stable, no beat lost or reordered after release.
- i_data_last at k=3 with LOG2_N=3 -> o_frame_err high one cycle; next beat treated as k=0, f=0; assert i_clear mid-frame -> o_data_valid=0 next cycle, counters restart.
- DATA_W=24; re=im=-2^23 -> o_data=2^47 exactly. Assert i_rst_n=0 mid-output -> o_data_valid drops asynchronously; all outputs return to 0.
